// File: rtl/mealy_pkg.sv
// Shared types and defaults for the mealy serial feeder.
// Holds the feeder FSM state type and the default frame header pattern.
// No logic lives here.
package mealy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } feeder_state_t;

  // Default two-bit frame header, sent MSB first.
  localparam logic [1:0] CODE_DEF = 2'b10;

endpackage : mealy_pkg

// File: rtl/mealy_bit_counter.sv
// Loadable down-counter with a zero flag, used to pace header and data bits.
// Latency: load/decrement take effect on the next clk edge; zero is combinational from the count.
// Backpressure: none; it holds at zero and only leaves zero through a reload.
module mealy_bit_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reload wins, otherwise step down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule : mealy_bit_counter

// File: rtl/mealy_serial_feeder.sv
// Serialises valid/ready words onto x as header + MSB-first data frames (optional parity: MEALY_FEEDER_PARITY_EN).
// Latency: word accepted at edge N puts the first header bit on x in cycle N+1; done follows the last bit.
// Backpressure: in_ready is high only in IDLE; in_valid while a frame is in flight is ignored.
module mealy_serial_feeder
  import mealy_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                CODE_W = 2,
  parameter logic [CODE_W-1:0] CODE   = CODE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              x_valid,
  output logic              dcontrol,
  output logic [DATA_W-1:0] data_out,
  output logic              done
);

  // Wide enough to hold DATA_W-1 and CODE_W-1 as "bits remaining after this one".
  localparam int CW = $clog2(DATA_W + 1);

  feeder_state_t     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              x_q, x_d;
  logic              x_valid_q, x_valid_d;
  logic              dcontrol_q, dcontrol_d;
  logic              done_q, done_d;

  logic              cnt_load;
  logic [CW-1:0]     cnt_load_val;
  logic              cnt_dec;
  logic [CW-1:0]     cnt;
  logic              cnt_zero;
  logic [CW-1:0]     cnt_nxt;
  logic [CODE_W-1:0] code_sh;
  logic [DATA_W-1:0] data_sh;

  // The counter holds the index of the bit currently on x; the next bit
  // to drive is one position lower.
  mealy_bit_counter #(
    .W (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign cnt_nxt = cnt - CW'(1);
  assign code_sh = CODE >> cnt_nxt;
  assign data_sh = data_q >> cnt_nxt;

  // Frame sequencing: each branch computes what the outputs show next cycle.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    x_d          = 1'b0;
    x_valid_d    = 1'b0;
    dcontrol_d   = 1'b0;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d      = HEAD;
          data_d       = in_data;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(CODE_W - 1);
          x_d          = CODE[CODE_W-1];
          x_valid_d    = 1'b1;
          dcontrol_d   = 1'b1;
        end
      end
      HEAD: begin
        x_valid_d  = 1'b1;
        dcontrol_d = 1'b1;
        if (cnt_zero) begin
          state_d      = DATA;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(DATA_W - 1);
          x_d          = data_q[DATA_W-1];
        end else begin
          cnt_dec = 1'b1;
          x_d     = code_sh[0];
        end
      end
      DATA: begin
        if (cnt_zero) begin
`ifdef MEALY_FEEDER_PARITY_EN
          state_d    = PAR;
          x_d        = ^data_q;
          x_valid_d  = 1'b1;
          dcontrol_d = 1'b1;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_dec    = 1'b1;
          x_d        = data_sh[0];
          x_valid_d  = 1'b1;
          dcontrol_d = 1'b1;
        end
      end
      PAR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, word and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      x_q        <= 1'b0;
      x_valid_q  <= 1'b0;
      dcontrol_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      x_q        <= x_d;
      x_valid_q  <= x_valid_d;
      dcontrol_q <= dcontrol_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign dcontrol = dcontrol_q;
  assign data_out = data_q;
  assign done     = done_q;

endmodule : mealy_serial_feeder

// File: tb/tb_mealy_serial_feeder.sv
// Bench for mealy_serial_feeder: directed and random words against a frame-bit model.
// Expected frames are built as bit queues from header, MSB-first data and optional parity.
// Honours MEALY_FEEDER_PARITY_EN to expect the extra parity bit.
module tb_mealy_serial_feeder;

  localparam int DATA_W = 32;
  localparam int CODE_W = 2;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              x;
  logic              x_valid;
  logic              dcontrol;
  logic [DATA_W-1:0] data_out;
  logic              done;

  int checks = 0;
  int errors = 0;

  mealy_serial_feeder #(
    .DATA_W (DATA_W),
    .CODE_W (CODE_W),
    .CODE   (2'b10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .x_valid  (x_valid),
    .dcontrol (dcontrol),
    .data_out (data_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference frame: header MSB first, data MSB first, then even parity when enabled.
  function automatic void build_frame(input logic [31:0] w, output bit q[$]);
    logic [CODE_W-1:0] hdr;
    hdr = 2'b10;
    q = {};
    for (int i = CODE_W - 1; i >= 0; i--) q.push_back(hdr[i]);
    for (int i = DATA_W - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef MEALY_FEEDER_PARITY_EN
    q.push_back(($countones(w) % 2) == 1);
`endif
  endfunction

  // Called at a negedge while idle: offer one word for exactly one edge.
  task automatic start_word(input logic [31:0] w);
    check("ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Checks the first nbits frame cycles; if the whole frame was checked, also the done cycle.
  task automatic check_frame(input logic [31:0] w, input bit stall, input int nbits);
    bit q[$];
    build_frame(w, q);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      check($sformatf("x_bit%0d", i), 32'(x), 32'(q[i]));
      check("x_valid_in_frame", 32'(x_valid), 32'd1);
      check("dcontrol_in_frame", 32'(dcontrol), 32'd1);
      check("data_out_held", data_out, w);
      check("ready_low_busy", 32'(in_ready), 32'd0);
      check("done_low_in_frame", 32'(done), 32'd0);
      if (stall && i == 12) begin
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
      end
      if (stall && i == 13) in_valid = 1'b0;
    end
    if (nbits == q.size()) begin
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("dcontrol_done", 32'(dcontrol), 32'd0);
      check("x_valid_done", 32'(x_valid), 32'd0);
      check("x_done", 32'(x), 32'd0);
      check("ready_done", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    bit          q[$];
    logic [31:0] w;
    int          flen;
    build_frame(32'h0, q);
    flen = q.size();

    // Reset state
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_x", 32'(x), 32'd0);
    check("rst_x_valid", 32'(x_valid), 32'd0);
    check("rst_dcontrol", 32'(dcontrol), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);
    check("done_after_rst", 32'(done), 32'd0);

    // Single directed word
    start_word(32'hA5A5_0F0F);
    check_frame(32'hA5A5_0F0F, 1'b0, flen);
    @(negedge clk);
    check("idle_after_done", 32'(done), 32'd0);

    // Back-to-back with in_valid held high; second word taken in the done cycle
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_data = 32'hFFFF_FFFF;
    check_frame(32'h0000_0001, 1'b0, flen);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_frame(32'hFFFF_FFFF, 1'b0, flen);

    // Busy stall: mid-frame pulse must be ignored and not consumed later
    @(negedge clk);
    w = $urandom;
    start_word(w);
    check_frame(w, 1'b1, flen);
    @(negedge clk);
    check("stall_not_consumed_xv", 32'(x_valid), 32'd0);
    check("stall_not_consumed_dc", 32'(dcontrol), 32'd0);
    check("stall_ready", 32'(in_ready), 32'd1);

    // Reset mid-DATA after bit 10: immediate clear, no done
    w = $urandom;
    start_word(w);
    check_frame(w, 1'b0, CODE_W + 10);
    #2;
    rst = 1'b1;
    #1;
    check("abort_x", 32'(x), 32'd0);
    check("abort_x_valid", 32'(x_valid), 32'd0);
    check("abort_dcontrol", 32'(dcontrol), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data_out", data_out, 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
      check("no_frame_after_abort", 32'(x_valid), 32'd0);
    end
    w = $urandom;
    start_word(w);
    check_frame(w, 1'b0, flen);

    // Random and boundary words, back-to-back through the done cycle
    for (int n = 0; n < 8; n++) begin
      if (n == 0) w = 32'h0000_0000;
      else if (n == 1) w = 32'h8000_0000;
      else w = $urandom;
      start_word(w);
      check_frame(w, 1'b0, flen);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mealy_serial_feeder
